// File: rtl/mux8_rr_scheduler.sv
// rtl/mux8_rr_scheduler.sv - round-robin scheduler driving an 8:1 mux select and active-low enable
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous reset, active-high
//   req    [7:0] request lines, req[i]=1 means requester i wants the mux
//   sel    [2:0] mux select, index of the current or last granted requester
//   en_n   mux enable, active-low, 0 while a grant is active
//   grant  [7:0] one-hot grant, all zeros when no grant is active
//   busy   1 while a grant is active
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles for one grant (1..255)
//   HOLD_W    hold counter width, 2**HOLD_W > MAX_HOLD
//
// Build option:
//   MUX_SCHED_GAP_EN  when defined, one dead cycle (en_n=1) separates any two
//                     grants; when undefined, the next grant is loaded on the
//                     same edge the previous one ends.
module mux8_rr_scheduler #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en_n,
    output logic [7:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nx;
    logic [2:0]        ptr, ptr_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [2:0]        sel_nx;
    logic              en_n_nx;
    logic [7:0]        grant_nx;
    logic              busy_nx;

    // Circular first-set search starting at p. Result bit 3 flags a winner,
    // bits 2:0 hold its index. Scanning from the far end down lets the
    // nearest requester overwrite any farther one.
    function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] exit_ptr;
    logic [3:0] arb_ptr;
    logic [3:0] arb_exit;
    logic [3:0] pick;
    logic       do_arb;

    // Pointer the grant hands over to when it ends; also the search start
    // for the back-to-back case where the next grant loads on the exit edge.
    assign exit_ptr = sel + 3'd1;
    assign arb_ptr  = arbitrate(req, ptr);
    assign arb_exit = arbitrate(req, exit_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            sel      <= 3'd0;
            en_n     <= 1'b1;
            grant    <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            sel      <= sel_nx;
            en_n     <= en_n_nx;
            grant    <= grant_nx;
            busy     <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        sel_nx   = sel;
        en_n_nx  = en_n;
        grant_nx = grant;
        busy_nx  = busy;
        do_arb   = 1'b1;
        pick     = arb_ptr;

        case (state)
            GRANT: begin
                if (req[sel] && (hold_cnt != HOLD_LAST)) begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                    do_arb  = 1'b0;
                end else begin
                    ptr_nx = exit_ptr;
`ifdef MUX_SCHED_GAP_EN
                    do_arb   = 1'b0;
                    state_nx = GAP;
                    en_n_nx  = 1'b1;
                    grant_nx = 8'h00;
                    busy_nx  = 1'b0;
`else
                    // ptr register is not updated yet, so search from the
                    // post-exit pointer directly.
                    pick = arb_exit;
`endif
                end
            end
            default: begin
                // IDLE and GAP both arbitrate from the stored pointer.
                pick = arb_ptr;
            end
        endcase

        if (do_arb) begin
            if (pick[3]) begin
                state_nx = GRANT;
                sel_nx   = pick[2:0];
                grant_nx = 8'h01 << pick[2:0];
                en_n_nx  = 1'b0;
                busy_nx  = 1'b1;
                hold_nx  = '0;
            end else begin
                // sel keeps the last granted index while idle.
                state_nx = IDLE;
                en_n_nx  = 1'b1;
                grant_nx = 8'h00;
                busy_nx  = 1'b0;
            end
        end
    end

endmodule
